mac_row_dual: RTL and testbench

Parametrised next-generation MAC row for the systolic array: `col` processing elements in a line, with activations and instructions pipelined west-to-east one tile per cycle, and partial sums exchanged north-to-south. Each tile supports two dataflows selected per instruction: weight-stationary (WS), where psums flow through, and output-stationary (OS), where psums accumulate locally and are drained on command. Weight loading is self-steering through per-tile loaded flags, and the row reports when all weights are resident.

---
 rtl/mac_row_dual.sv | 171 +++++++++++++++++
 tb/tb_mac_row_dual.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_dual.sv
// mac_row_dual: a row of `col` MAC tiles for the systolic array.
// Activations, instructions and mode travel west-to-east one tile per cycle.
// North psums feed each column, and registered south psums leave each column.
// Each tile runs one of two dataflows, chosen per instruction:
//   WS (weight-stationary): the psum flows through the tile.
//   OS (output-stationary): the tile accumulates locally and drains on command.
// Weights self-steer: a load token fills the first tile whose loaded flag is
// clear, and that tile consumes the token.
// Optional build macro: MAC_ROW_DUAL_SAT_EN. When it is defined, WS sums and
// OS accumulation saturate; otherwise they wrap.
// Assumes psum_bw > 2*bw+1.

module mac_row_dual #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bw-1:0]            in_w,
    input  logic [2:0]               inst_w,
    input  logic                     mode_w,
    input  logic                     w_clr,
    input  logic [psum_bw*col-1:0]   in_n,
    output logic [psum_bw*col-1:0]   out_s,
    output logic [col-1:0]           valid,
    output logic                     w_full
);

    localparam int PW  = 2 * bw + 1;
    localparam int EXT = psum_bw - PW;

    localparam logic [2:0] InstIdle  = 3'b000;
    localparam logic [2:0] InstLoad  = 3'b001;
    localparam logic [2:0] InstExec  = 3'b010;
    localparam logic [2:0] InstDrain = 3'b100;

    // Unsigned activation times signed operand, sign-extended to psum width.
    function automatic logic [psum_bw-1:0] f_mul(input logic [bw-1:0] i_a,
                                                 input logic [bw-1:0] i_b);
        logic signed [PW-1:0] w_a;
        logic signed [PW-1:0] w_b;
        logic signed [PW-1:0] w_p;
        w_a = $signed({{(PW-bw){1'b0}}, i_a});
        w_b = $signed({{(PW-bw){i_b[bw-1]}}, i_b});
        w_p = w_a * w_b;
        return {{EXT{w_p[PW-1]}}, w_p};
    endfunction

`ifdef MAC_ROW_DUAL_SAT_EN
    // Signed add that clamps to the psum range.
    function automatic logic [psum_bw-1:0] f_add(input logic [psum_bw-1:0] i_x,
                                                 input logic [psum_bw-1:0] i_y);
        logic [psum_bw:0] w_s;
        w_s = {i_x[psum_bw-1], i_x} + {i_y[psum_bw-1], i_y};
        if (w_s[psum_bw] != w_s[psum_bw-1]) begin
            return w_s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end
        return w_s[psum_bw-1:0];
    endfunction
`else
    // Signed add that wraps modulo 2^psum_bw.
    function automatic logic [psum_bw-1:0] f_add(input logic [psum_bw-1:0] i_x,
                                                 input logic [psum_bw-1:0] i_y);
        return i_x + i_y;
    endfunction
`endif

    logic [col-1:0] w_wld;
    logic           r_full;

    for (genvar j = 0; j < col; j++) begin : g_tile
        logic [bw-1:0]      r_a;
        logic [2:0]         r_inst;
        logic               r_mode;
        logic [bw-1:0]      r_w;
        logic               r_wld;
        logic [psum_bw-1:0] r_acc;
        logic [psum_bw-1:0] r_out;
        logic               r_valid;

        logic [bw-1:0]      w_a_in;
        logic [2:0]         w_inst_in;
        logic               w_mode_in;
        logic [psum_bw-1:0] w_n;

        if (j == 0) begin : g_head
            assign w_a_in    = in_w;
            assign w_inst_in = inst_w;
            assign w_mode_in = mode_w;
        end else begin : g_body
            assign w_a_in    = g_tile[j-1].r_a;
            assign w_inst_in = g_tile[j-1].r_inst;
            assign w_mode_in = g_tile[j-1].r_mode;
        end

        assign w_n = in_n[psum_bw*j +: psum_bw];

        // Tile state: pipeline forwarding, weight capture, WS/OS compute, drain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_a     <= '0;
                r_inst  <= '0;
                r_mode  <= 1'b0;
                r_w     <= '0;
                r_wld   <= 1'b0;
                r_acc   <= '0;
                r_out   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_a     <= w_a_in;
                r_inst  <= w_inst_in;
                r_mode  <= w_mode_in;
                r_valid <= 1'b0;
                case (w_inst_in)
                    InstLoad: begin
                        // A load that fills this tile, or that collides with a
                        // clear, is consumed here so it cannot load further east.
                        if (w_clr || !r_wld) begin
                            r_inst <= InstIdle;
                        end
                        if (!w_clr && !r_wld) begin
                            r_w   <= w_a_in;
                            r_wld <= 1'b1;
                        end
                    end
                    InstExec: begin
                        if (!w_mode_in) begin
                            r_out   <= f_add(w_n, f_mul(w_a_in, r_w));
                            r_valid <= 1'b1;
                        end else begin
                            r_acc <= f_add(r_acc, f_mul(w_a_in, w_n[bw-1:0]));
                        end
                    end
                    InstDrain: begin
                        if (w_mode_in) begin
                            r_out   <= r_acc;
                            r_acc   <= '0;
                            r_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (w_clr) begin
                    r_w   <= '0;
                    r_wld <= 1'b0;
                end
            end
        end

        assign out_s[psum_bw*j +: psum_bw] = r_out;
        assign valid[j]                    = r_valid;
        assign w_wld[j]                    = r_wld;
    end

    // Registered "all weights resident" flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
        end else begin
            r_full <= &w_wld;
        end
    end

    assign w_full = r_full;

    // The last tile's forwarded pipeline registers have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{g_tile[col-1].r_a, g_tile[col-1].r_inst, g_tile[col-1].r_mode};

endmodule

// File: tb/tb_mac_row_dual.sv
// Directed, table-driven bench for mac_row_dual (col=8, bw=4, psum_bw=16).
module tb_mac_row_dual;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [BW-1:0]          in_w;
    logic [2:0]             inst_w;
    logic                   mode_w;
    logic                   w_clr;
    logic [PSUM_BW*COL-1:0] in_n;
    logic [PSUM_BW*COL-1:0] out_s;
    logic [COL-1:0]         valid;
    logic                   w_full;

    int checks = 0;
    int errors = 0;

    int wts [COL] = '{1, 2, 3, 4, 5, 6, 7, -8};

    typedef struct {
        logic [3:0]  a;
        logic [15:0] n;
        logic [15:0] exp0;
        logic [15:0] exp7;
    } ws_vec_t;

    ws_vec_t tbl [5];

    mac_row_dual #(
        .bw      (BW),
        .psum_bw (PSUM_BW),
        .col     (COL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .inst_w (inst_w),
        .mode_w (mode_w),
        .w_clr  (w_clr),
        .in_n   (in_n),
        .out_s  (out_s),
        .valid  (valid),
        .w_full (w_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] col_out(input int j);
        return out_s[16*j +: 16];
    endfunction

    task automatic set_n_all(input logic [15:0] v);
        for (int j = 0; j < COL; j++) in_n[16*j +: 16] = v;
    endtask

    task automatic load_row();
        logic [3:0] wv;
        for (int n = 0; n < COL; n++) begin
            wv     = 4'(wts[n]);
            in_w   = wv;
            inst_w = 3'b001;
            tick();
        end
        inst_w = 3'b000;
        in_w   = '0;
    endtask

    // Single WS execute already issued; walk it across the row.
    task automatic walk_ws(input string name, input logic [15:0] n_all, input logic [3:0] a);
        logic [7:0]  ev;
        logic [15:0] e;
        for (int j = 0; j < COL; j++) begin
            ev = 8'b1 << j;
            e  = 16'(int'($signed(n_all)) + int'(a) * wts[j]);
            chk({name, "_valid"}, 32'(valid), 32'(ev));
            chk({name, "_out"}, 32'(col_out(j)), 32'(e));
            if (j < COL - 1) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ev;
        logic       seen;
        tbl[0] = '{a: 4'd3,  n: 16'd100,   exp0: 16'd103,   exp7: 16'd76};
        tbl[1] = '{a: 4'd0,  n: 16'h1234,  exp0: 16'h1234,  exp7: 16'h1234};
        tbl[2] = '{a: 4'd15, n: 16'h0000,  exp0: 16'h000F,  exp7: 16'hFF88};
        tbl[3] = '{a: 4'd1,  n: 16'hFFFF,  exp0: 16'h0000,  exp7: 16'hFFF7};
        tbl[4] = '{a: 4'd10, n: 16'd50,    exp0: 16'h003C,  exp7: 16'hFFE2};

        reset  = 1'b0;
        in_w   = '0;
        inst_w = '0;
        mode_w = 1'b0;
        w_clr  = 1'b0;
        in_n   = '0;
        repeat (2) tick();
        chk("rst_out", 32'(|out_s), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_full", 32'(w_full), 32'd0);
        reset = 1'b1;

        // Weight load: last tile loads at edge 15, w_full rises at edge 16.
        load_row();
        repeat (7) tick();
        chk("load_full_early", 32'(w_full), 32'd0);
        tick();
        chk("load_full", 32'(w_full), 32'd1);

        // WS execute vectors; per-column checks also confirm each tile's weight.
        for (int v = 0; v < 5; v++) begin
            set_n_all(tbl[v].n);
            in_w   = tbl[v].a;
            inst_w = 3'b010;
            mode_w = 1'b0;
            tick();
            inst_w = 3'b000;
            in_w   = '0;
            chk("ws_tbl_col0", 32'(col_out(0)), 32'(tbl[v].exp0));
            walk_ws("ws_tbl", tbl[v].n, tbl[v].a);
            chk("ws_tbl_col7", 32'(col_out(7)), 32'(tbl[v].exp7));
            tick();
            chk("ws_tbl_idle_valid", 32'(valid), 32'd0);
        end

        // OS: four accumulates of 5*2 then a drain gives 40 in every column.
        set_n_all(16'h0002);
        mode_w = 1'b1;
        in_w   = 4'd5;
        inst_w = 3'b010;
        repeat (4) tick();
        chk("os_exec_valid", 32'(valid), 32'd0);
        in_w   = '0;
        inst_w = 3'b100;
        tick();
        inst_w = 3'b000;
        for (int j = 0; j < COL; j++) begin
            ev = 8'b1 << j;
            chk("os_drain_valid", 32'(valid), 32'(ev));
            chk("os_drain_out", 32'(col_out(j)), 32'd40);
            if (j < COL - 1) tick();
        end
        inst_w = 3'b100;
        tick();
        inst_w = 3'b000;
        for (int j = 0; j < COL; j++) begin
            ev = 8'b1 << j;
            chk("os_drain2_valid", 32'(valid), 32'(ev));
            chk("os_drain2_out", 32'(col_out(j)), 32'd0);
            if (j < COL - 1) tick();
        end
        mode_w = 1'b0;

        // Async reset in the middle of a stream of executes.
        set_n_all(16'd77);
        in_w   = 4'd3;
        inst_w = 3'b010;
        tick();
        tick();
        chk("arst_pre_full", 32'(w_full), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_out", 32'(|out_s), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_full", 32'(w_full), 32'd0);
        tick();
        inst_w = 3'b000;
        in_w   = '0;
        reset  = 1'b1;
        for (int j = 0; j < COL; j++) in_n[16*j +: 16] = 16'h0100 + 16'(j);
        in_w   = 4'd9;
        inst_w = 3'b010;
        tick();
        inst_w = 3'b000;
        for (int j = 0; j < COL; j++) begin
            ev = 8'b1 << j;
            chk("arst_post_valid", 32'(valid), 32'(ev));
            chk("arst_post_out", 32'(col_out(j)), 32'h100 + 32'(j));
            if (j < COL - 1) tick();
        end

        // Reload, then clear all weights.
        load_row();
        repeat (8) tick();
        chk("reload_full", 32'(w_full), 32'd1);
        w_clr = 1'b1;
        tick();
        w_clr = 1'b0;
        tick();
        chk("clr_full", 32'(w_full), 32'd0);

        // Illegal code 011 acts as idle: no valid pulses, no weights loaded.
        seen   = 1'b0;
        in_w   = 4'd5;
        inst_w = 3'b011;
        repeat (4) begin
            tick();
            seen = seen | (|valid);
        end
        inst_w = 3'b000;
        in_w   = '0;
        repeat (10) begin
            tick();
            seen = seen | (|valid);
        end
        chk("illegal_valid", 32'(seen), 32'd0);
        chk("illegal_full", 32'(w_full), 32'd0);
        for (int j = 0; j < COL; j++) in_n[16*j +: 16] = 16'h0200 + 16'(j);
        in_w   = 4'd6;
        inst_w = 3'b010;
        tick();
        inst_w = 3'b000;
        for (int j = 0; j < COL; j++) begin
            chk("illegal_noload_out", 32'(col_out(j)), 32'h200 + 32'(j));
            if (j < COL - 1) tick();
        end

        // WS overflow: 0x7FFF + 15*7 at tile 0.
        in_w   = 4'd7;
        inst_w = 3'b001;
        tick();
        inst_w = 3'b000;
        tick();
        set_n_all(16'h7FFF);
        in_w   = 4'd15;
        inst_w = 3'b010;
        tick();
        inst_w = 3'b000;
        chk("ovf_valid0", 32'(valid[0]), 32'd1);
`ifdef MAC_ROW_DUAL_SAT_EN
        chk("ovf_out0", 32'(col_out(0)), 32'h7FFF);
`else
        chk("ovf_out0", 32'(col_out(0)), 32'h8068);
`endif
        tick();
        chk("ovf_col1_w0", 32'(col_out(1)), 32'h7FFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
